// File: rtl/alu_pkg.sv
// Shared opcode encodings for the pipelined ALU.
//   ARITH_*      : op[2:0] codes when op[OP_LOGIC_BIT] = 0 (adder B operand and carry-in)
//   LOGIC_*      : op[1:0] codes when op[OP_LOGIC_BIT] = 1
//   SHDIR_*      : shift direction encoding
package alu_pkg;

  // Adder codes: bits [2:1] pick the B operand, bit [0] is the carry-in.
  localparam logic [2:0] ARITH_PASS  = 3'b000; // x
  localparam logic [2:0] ARITH_INC   = 3'b001; // x + 1
  localparam logic [2:0] ARITH_ADD   = 3'b010; // x + y
  localparam logic [2:0] ARITH_ADDC  = 3'b011; // x + y + 1
  localparam logic [2:0] ARITH_SUBB  = 3'b100; // x - y - 1
  localparam logic [2:0] ARITH_SUB   = 3'b101; // x - y
  localparam logic [2:0] ARITH_DEC   = 3'b110; // x - 1
  localparam logic [2:0] ARITH_PASSC = 3'b111; // x, with carry out set

  localparam logic [1:0] LOGIC_AND = 2'b00;
  localparam logic [1:0] LOGIC_OR  = 2'b01;
  localparam logic [1:0] LOGIC_XOR = 2'b10;
  localparam logic [1:0] LOGIC_NOT = 2'b11;

  localparam int unsigned OP_LOGIC_BIT = 3;

  localparam logic SHDIR_LEFT  = 1'b0;
  localparam logic SHDIR_RIGHT = 1'b1;

endpackage

// File: rtl/alu_barrel_shifter.sv
// Combinational log2 barrel shifter.
//   data_i    : value to shift
//   shamt_i   : shift amount (0 = pass-through)
//   shdir_i   : SHDIR_LEFT / SHDIR_RIGHT
//   sharith_i : sign-fill on right shifts; ignored on left shifts
//   outp_o    : shifted value
module alu_barrel_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic             shdir_i,
  input  logic             sharith_i,
  output logic [WIDTH-1:0] outp_o
);

  logic [SHW:0][WIDTH-1:0] lvl;
  logic                    fill;

  // Fill bit is constant across levels: the original sign stays the sign.
  assign fill   = (shdir_i == SHDIR_RIGHT) && sharith_i && data_i[WIDTH-1];
  assign lvl[0] = data_i;

  for (genvar i = 0; i < SHW; i++) begin : g_lvl
    localparam int unsigned Amt = 1 << i;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;

    assign shl        = {lvl[i][WIDTH-1-Amt:0], {Amt{1'b0}}};
    assign shr        = {{Amt{fill}}, lvl[i][WIDTH-1:Amt]};
    assign lvl[i+1]   = !shamt_i[i]                ? lvl[i] :
                        (shdir_i == SHDIR_RIGHT)   ? shr    : shl;
  end

  assign outp_o = lvl[SHW];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
//   Stage 1: adder / logic unit / op mux -> s1 registers (value, cout, ovf, shift controls)
//   Stage 2: barrel shift + zero/neg flags -> output registers
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : operand beat handshake (x, y, op, shamt, shdir, sharith)
//   out_valid/out_ready   : result beat handshake (result, cout, zero, neg, ovf)
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic             shdir,
  input  logic             sharith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int unsigned Msb = WIDTH - 1;

  logic             adv1, adv2;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_val_q;
  logic             s1_cout_q, s1_ovf_q;
  logic [SHW-1:0]   s1_shamt_q;
  logic             s1_shdir_q, s1_sharith_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q, zero_q, neg_q, ovf_q;

  logic [WIDTH-1:0] au_b, lu_res, s1_val_d, sh_out;
  logic [WIDTH:0]   au_sum;
  logic             au_ovf, s1_cout_d, s1_ovf_d;

  // A stage may load when it is empty or its content moves on this edge.
  always_comb begin
    adv2 = !s2_valid_q || out_ready;
    adv1 = !s1_valid_q || adv2;
  end

  // Reset flushes everything, so a beat offered during reset can be taken (and dropped).
  assign in_ready = adv1 || !rst_n;

  // Arithmetic unit
  always_comb begin
    au_b = '0;
    case (op[2:0])
      ARITH_PASS, ARITH_INC:  au_b = '0;
      ARITH_ADD,  ARITH_ADDC: au_b = y;
      ARITH_SUBB, ARITH_SUB:  au_b = ~y;
      ARITH_DEC,  ARITH_PASSC: au_b = '1;
      default:                au_b = '0;
    endcase
  end

  // Carry-in is op[0] for every arithmetic code.
  assign au_sum = {1'b0, x} + {1'b0, au_b} + {{WIDTH{1'b0}}, op[0]};
  assign au_ovf = (x[Msb] == au_b[Msb]) && (au_sum[Msb] != x[Msb]);

  // Logic unit
  always_comb begin
    lu_res = '0;
    case (op[1:0])
      LOGIC_AND: lu_res = x & y;
      LOGIC_OR:  lu_res = x | y;
      LOGIC_XOR: lu_res = x ^ y;
      LOGIC_NOT: lu_res = ~x;
      default:   lu_res = '0;
    endcase
  end

  // Op mux
  always_comb begin
    s1_val_d  = au_sum[WIDTH-1:0];
    s1_cout_d = au_sum[WIDTH];
    s1_ovf_d  = au_ovf;
    if (op[OP_LOGIC_BIT]) begin
      s1_val_d  = lu_res;
      s1_cout_d = 1'b0;
      s1_ovf_d  = 1'b0;
    end
  end

  alu_barrel_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift (
    .data_i    (s1_val_q),
    .shamt_i   (s1_shamt_q),
    .shdir_i   (s1_shdir_q),
    .sharith_i (s1_sharith_q),
    .outp_o    (sh_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_val_q     <= '0;
      s1_cout_q    <= 1'b0;
      s1_ovf_q     <= 1'b0;
      s1_shamt_q   <= '0;
      s1_shdir_q   <= 1'b0;
      s1_sharith_q <= 1'b0;
      s2_valid_q   <= 1'b0;
      result_q     <= '0;
      cout_q       <= 1'b0;
      zero_q       <= 1'b0;
      neg_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid_q <= in_valid;
      end
      if (adv1 && in_valid) begin
        s1_val_q     <= s1_val_d;
        s1_cout_q    <= s1_cout_d;
        s1_ovf_q     <= s1_ovf_d;
        s1_shamt_q   <= shamt;
        s1_shdir_q   <= shdir;
        s1_sharith_q <= sharith;
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
      end
      // Output registers only change on a new beat, keeping stalled outputs bit-stable.
      if (adv2 && s1_valid_q) begin
        result_q <= sh_out;
        cout_q   <= s1_cout_q;
        ovf_q    <= s1_ovf_q;
        zero_q   <= ~|sh_out;
        neg_q    <= sh_out[Msb];
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: an 8-bit and a 16-bit instance driven in lockstep, each checked
// against an arithmetic reference model through its own in-order scoreboard.
module tb_alu_pipe;

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] x_in, y_in;
  logic [3:0]  op;
  logic [3:0]  shamt;
  logic        shdir, sharith;

  logic        in_ready8, out_valid8, cout8, zero8, neg8, ovf8;
  logic [7:0]  result8;
  logic        in_ready16, out_valid16, cout16, zero16, neg16, ovf16;
  logic [15:0] result16;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q8[$];
  exp_t q16[$];
  int   n_pop8 = 0;
  bit   hold8 = 0, hold16 = 0;
  bit   acc;

  alu_pipe #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .x         (x_in[7:0]),
    .y         (y_in[7:0]),
    .op        (op),
    .shamt     (shamt[2:0]),
    .shdir     (shdir),
    .sharith   (sharith),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .result    (result8),
    .cout      (cout8),
    .zero      (zero8),
    .neg       (neg8),
    .ovf       (ovf8)
  );

  alu_pipe #(.WIDTH(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready16),
    .x         (x_in),
    .y         (y_in),
    .op        (op),
    .shamt     (shamt),
    .shdir     (shdir),
    .sharith   (sharith),
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .result    (result16),
    .cout      (cout16),
    .zero      (zero16),
    .neg       (neg16),
    .ovf       (ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: sum at w+1 bits, then shift with plain integer arithmetic.
  function automatic exp_t model(input int unsigned w, input logic [15:0] xi, input logic [15:0] yi,
                                 input logic [3:0] o, input logic [3:0] sh, input logic dir,
                                 input logic sa);
    int unsigned mask, xv, yv, b, s, v, amt, top;
    int          sv;
    exp_t        e;
    e    = '0;
    mask = (32'd1 << w) - 1;
    top  = 32'd1 << (w - 1);
    xv   = 32'(xi) & mask;
    yv   = 32'(yi) & mask;
    if (o[3]) begin
      case (o[1:0])
        2'd0:    v = xv & yv;
        2'd1:    v = xv | yv;
        2'd2:    v = xv ^ yv;
        default: v = ~xv & mask;
      endcase
    end else begin
      case (o[2:1])
        2'd0:    b = 0;
        2'd1:    b = yv;
        2'd2:    b = ~yv & mask;
        default: b = mask;
      endcase
      s      = xv + b + 32'(o[0]);
      v      = s & mask;
      e.cout = (s > mask);
      e.ovf  = (((xv & top) != 0) == ((b & top) != 0)) && (((v & top) != 0) != ((xv & top) != 0));
    end
    amt = 32'(sh) & (w - 1);
    if (!dir) begin
      v = (v << amt) & mask;
    end else if (sa && ((v & top) != 0)) begin
      sv = int'(v) - int'(mask) - 1;
      sv = sv >>> amt;
      v  = int'(sv) & mask;
    end else begin
      v = v >> amt;
    end
    e.res  = v[15:0];
    e.zero = (v == 0);
    e.neg  = ((v & top) != 0);
    return e;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input logic [15:0] r, input logic c,
                     input logic z, input logic n, input logic o);
    chk({tag, "_result"}, 32'(r), 32'(e.res));
    chk({tag, "_cout"},   32'(c), 32'(e.cout));
    chk({tag, "_zero"},   32'(z), 32'(e.zero));
    chk({tag, "_neg"},    32'(n), 32'(e.neg));
    chk({tag, "_ovf"},    32'(o), 32'(e.ovf));
  endtask

  // One clock: check visible outputs, account handshakes, cross the edge.
  task automatic cycle(output bit accepted);
    exp_t e;
    #2;
    accepted = 0;
    if (!rst_n) begin
      chk("rst_in_ready8", 32'(in_ready8), 1);
      chk("rst_in_ready16", 32'(in_ready16), 1);
    end
    if (hold8)  chk("hold_valid8", 32'(out_valid8), 1);
    if (hold16) chk("hold_valid16", 32'(out_valid16), 1);
    if (out_valid8 === 1'b1) begin
      if (q8.size() == 0) chk("spurious_beat8", 32'(out_valid8), 0);
      else cmp("out8", q8[0], {8'h00, result8}, cout8, zero8, neg8, ovf8);
    end
    if (out_valid16 === 1'b1) begin
      if (q16.size() == 0) chk("spurious_beat16", 32'(out_valid16), 0);
      else cmp("out16", q16[0], result16, cout16, zero16, neg16, ovf16);
    end
    hold8  = rst_n && (out_valid8 === 1'b1) && !out_ready;
    hold16 = rst_n && (out_valid16 === 1'b1) && !out_ready;
    if (rst_n && out_ready && out_valid8 === 1'b1 && q8.size() > 0) begin
      void'(q8.pop_front());
      n_pop8++;
    end
    if (rst_n && out_ready && out_valid16 === 1'b1 && q16.size() > 0) void'(q16.pop_front());
    if (rst_n && in_valid && in_ready8 === 1'b1) begin
      e = model(8, x_in, y_in, op, shamt, shdir, sharith);
      q8.push_back(e);
      accepted = 1;
    end
    if (rst_n && in_valid && in_ready16 === 1'b1) begin
      e = model(16, x_in, y_in, op, shamt, shdir, sharith);
      q16.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q8.delete();
      q16.delete();
    end
  endtask

  task automatic set_beat(input logic [15:0] xv, input logic [15:0] yv, input logic [3:0] o,
                          input logic [3:0] sh, input logic d, input logic sa);
    x_in = xv; y_in = yv; op = o; shamt = sh; shdir = d; sharith = sa;
  endtask

  // Single beat through an idle pipe, latency check, then constant checks on both widths.
  task automatic directed(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                          input logic [3:0] o, input logic [3:0] sh, input logic d,
                          input logic sa, input exp_t c8, input exp_t c16);
    bit a;
    out_ready = 1;
    in_valid  = 1;
    set_beat(xv, yv, o, sh, d, sa);
    cycle(a);
    chk({tag, "_accept"}, 32'(a), 1);
    in_valid = 0;
    chk({tag, "_lat_early"}, 32'(out_valid8), 0);
    cycle(a);
    chk({tag, "_lat_valid8"}, 32'(out_valid8), 1);
    chk({tag, "_lat_valid16"}, 32'(out_valid16), 1);
    cmp({tag, "_k8"}, c8, {8'h00, result8}, cout8, zero8, neg8, ovf8);
    cmp({tag, "_k16"}, c16, result16, cout16, zero16, neg16, ovf16);
    cycle(a);
  endtask

  initial begin
    int start_pop;
    int idx;
    rst_n = 0; in_valid = 0; out_ready = 1;
    set_beat(16'h0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    cycle(acc);
    cycle(acc);
    rst_n = 1;
    chk("reset_out_valid8", 32'(out_valid8), 0);
    chk("reset_out_valid16", 32'(out_valid16), 0);
    chk("reset_result8", 32'(result8), 0);
    chk("reset_flags8", 32'({cout8, zero8, neg8, ovf8}), 0);
    chk("reset_flags16", 32'({cout16, zero16, neg16, ovf16}), 0);

    // res, cout, zero, neg, ovf
    directed("t1", 16'h00F0, 16'h0020, 4'b0010, 4'd0, 1'b0, 1'b0,
             {16'h0010, 1'b1, 1'b0, 1'b0, 1'b0}, {16'h0110, 1'b0, 1'b0, 1'b0, 1'b0});
    directed("t2", 16'h0080, 16'h0001, 4'b0101, 4'd0, 1'b0, 1'b0,
             {16'h007F, 1'b1, 1'b0, 1'b0, 1'b1}, {16'h007F, 1'b1, 1'b0, 1'b0, 1'b0});
    directed("t2w", 16'h8000, 16'h0001, 4'b0101, 4'd0, 1'b0, 1'b0,
             {16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0}, {16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1});
    directed("t3a", 16'h00A5, 16'h000F, 4'b1000, 4'd2, 1'b0, 1'b0,
             {16'h0014, 1'b0, 1'b0, 1'b0, 1'b0}, {16'h0014, 1'b0, 1'b0, 1'b0, 1'b0});
    directed("t3b", 16'h0080, 16'h0000, 4'b0000, 4'd3, 1'b1, 1'b1,
             {16'h00F0, 1'b0, 1'b0, 1'b1, 1'b0}, {16'h0010, 1'b0, 1'b0, 1'b0, 1'b0});
    directed("t3c", 16'h8000, 16'h0000, 4'b0000, 4'd3, 1'b1, 1'b1,
             {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}, {16'hF000, 1'b0, 1'b0, 1'b1, 1'b0});
    directed("t4", 16'h0033, 16'h0033, 4'b1010, 4'd0, 1'b0, 1'b0,
             {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}, {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0});

    // Stream of 4 beats into a stalled output.
    start_pop = n_pop8;
    idx = 0;
    for (int c = 0; c < 30 && (idx < 4 || q8.size() > 0); c++) begin
      in_valid  = (idx < 4);
      out_ready = (c >= 5);
      set_beat(16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
               1'($urandom));
      cycle(acc);
      if (c >= 2 && c <= 4) chk("stall_no_accept", 32'(acc), 0);
      if (acc) idx++;
    end
    in_valid = 0;
    chk("stream_emitted", 32'(n_pop8 - start_pop), 4);
    chk("stream_drained16", 32'(q16.size()), 0);

    // Reset with two beats in flight and output stalled.
    out_ready = 0;
    in_valid  = 1;
    for (int c = 0; c < 2; c++) begin
      set_beat(16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
               1'($urandom));
      cycle(acc);
    end
    chk("pre_reset_full", 32'(in_ready8), 0);
    rst_n = 0;
    cycle(acc);
    rst_n = 1; in_valid = 0; out_ready = 1;
    chk("post_reset_valid8", 32'(out_valid8), 0);
    chk("post_reset_valid16", 32'(out_valid16), 0);
    chk("post_reset_in_ready", 32'(in_ready8), 1);
    chk("post_reset_result16", 32'(result16), 0);
    for (int c = 0; c < 5; c++) cycle(acc);

    // Random traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 7);
      set_beat(16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
               1'($urandom));
      cycle(acc);
    end
    in_valid  = 0;
    out_ready = 1;
    for (int c = 0; c < 10 && (q8.size() > 0 || q16.size() > 0); c++) cycle(acc);
    chk("final_drain8", 32'(q8.size()), 0);
    chk("final_drain16", 32'(q16.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
